// File: rtl/tt_mux_sel_ctrl.sv
// Break-before-make sequencer for the mux spine select/enable lines and user reset.
// Optional TT_MUX_SEL_CTRL_RST_EN compiles in the post-enable user-reset hold phase.
module tt_mux_sel_ctrl #(
    parameter int unsigned GUARD_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned RST_CYC    = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_addr,
    input  logic        req_ena,
    output logic [9:0]  spine_sel,
    output logic        spine_ena,
    output logic        um_rst_n,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SEL_W = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACTIVE  = 3'd1,
        DISABLE = 3'd2,
`ifdef TT_MUX_SEL_CTRL_RST_EN
        SETTLE  = 3'd3,
        RESET   = 3'd4
`else
        SETTLE  = 3'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
`ifdef TT_MUX_SEL_CTRL_RST_EN
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
`else
    // RST_CYC has no effect without the reset phase.
    logic unused_rst_cyc;
    assign unused_rst_cyc = ^32'(RST_CYC);
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   addr_q;
    logic               ena_q;

    // Ready is a pure state decode so the handshake never sees the request inputs.
    assign req_ready = (state == IDLE) || (state == ACTIVE);
    assign busy      = !req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            ena_q     <= 1'b0;
            spine_sel <= '0;
            spine_ena <= 1'b0;
            um_rst_n  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ACTIVE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        ena_q     <= req_ena;
                        spine_ena <= 1'b0;
                        um_rst_n  <= 1'b0;
                        cnt       <= GUARD_LOAD;
                        state     <= DISABLE;
                    end
                end
                DISABLE: begin
                    if (cnt == '0) begin
                        spine_sel <= addr_q;
                        cnt       <= SETTLE_LOAD;
                        state     <= SETTLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        if (!ena_q) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            spine_ena <= 1'b1;
`ifdef TT_MUX_SEL_CTRL_RST_EN
                            cnt       <= RST_LOAD;
                            state     <= RESET;
`else
                            um_rst_n  <= 1'b1;
                            done      <= 1'b1;
                            state     <= ACTIVE;
`endif
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef TT_MUX_SEL_CTRL_RST_EN
                RESET: begin
                    if (cnt == '0) begin
                        um_rst_n <= 1'b1;
                        done     <= 1'b1;
                        state    <= ACTIVE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tt_mux_sel_ctrl.md
# tt_mux_sel_ctrl

Sequencer that drives the select and enable lines of the row/column mux spine. It accepts design-select requests over a valid/ready handshake and applies them with a break-before-make sequence: disable, guard, switch select, settle, enable, then release user reset. It sits between the chip control logic and the spine input bus, and owns the spine select field and the spine enable bit.

## Interface
Parameters:
- `GUARD_CYC`, default 2: cycles the old design stays disabled before the select changes. Must be ≥1.
- `SETTLE_CYC`, default 4: cycles the new select settles before enable. Must be ≥1.
- `RST_CYC`, default 8: cycles user reset is held after enable. Must be ≥1.
- `CNT_W`, default 4: phase counter width. Must satisfy 2^CNT_W > max(GUARD_CYC, SETTLE_CYC, RST_CYC).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_addr`  in  10  requested spine select value (row/branch bits plus column bits, passed through unchanged).
- `req_ena`  in  1  1 = select and enable; 0 = select and leave disabled.
- `spine_sel`  out  10  registered select driven onto the spine.
- `spine_ena`  out  1  registered spine enable.
- `um_rst_n`  out  1  reset to the selected user design, active-low.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, ACTIVE, DISABLE, SETTLE, RESET.
- Reset values: state IDLE, `spine_sel` = 0, `spine_ena` = 0, `um_rst_n` = 0, `done` = 0, counter = 0.
- `req_ready` = 1 only in IDLE or ACTIVE. `busy` = !`req_ready`.
- A request is accepted on an edge where `req_valid & req_ready`. At that edge, `req_addr` and `req_ena` are latched, `spine_ena` goes to 0, `um_rst_n` goes to 0, and the state moves to DISABLE. The full sequence always runs, even if `req_addr` equals the current `spine_sel`.
- DISABLE lasts `GUARD_CYC` cycles. On exit, `spine_sel` loads the latched address and the state moves to SETTLE.
- SETTLE lasts `SETTLE_CYC` cycles. On exit:
  - If the latched `req_ena` = 0: go to IDLE and pulse `done`.
  - Otherwise: `spine_ena` goes to 1 and the state moves to RESET. Without the macro, the state moves straight to ACTIVE; see Configuration.
- RESET lasts `RST_CYC` cycles with `um_rst_n` = 0. On exit, `um_rst_n` goes to 1, the state moves to ACTIVE, and `done` pulses.
- `um_rst_n` = 1 only in ACTIVE.
- Requests presented while busy are not accepted. `req_valid` may stay high, and the request is taken on the first edge at which the block is back in IDLE or ACTIVE.
- A `done` pulse and the acceptance of a new request may fall on the same edge. The new sequence starts normally.
- Reset asserted mid-sequence returns every output to its reset value on the next edge. No partial select is retained.

## Timing
Request accepted at edge k, with G = `GUARD_CYC`, S = `SETTLE_CYC`, R = `RST_CYC`:
- Edge k: `spine_ena` = 0, `req_ready` = 0.
- Edge k+G: `spine_sel` = new address.
- Edge k+G+S: `spine_ena` = 1, or IDLE with a `done` pulse if `req_ena` = 0.
- Edge k+G+S+R: `um_rst_n` = 1, `done` = 1 for one cycle, `req_ready` = 1.

Other timing rules:
- All outputs are registered; there is no combinational path from the request inputs to the spine outputs.
- `req_ready` is decoded from state only.
- Phase counter: loaded with N−1 on entry to a timed state, decremented each cycle, phase exits when it reaches 0. Total request-to-`done` latency is G+S+R cycles.

## Configuration
- `TT_MUX_SEL_CTRL_RST_EN` defined: the RESET state is compiled in, and user reset is held for `RST_CYC` cycles after enable.
- Undefined: RESET and the `RST_CYC` counter path are removed. SETTLE exits directly to ACTIVE with `spine_ena` = 1 and `um_rst_n` = 1 on the same edge, and `done` pulses at k+G+S. The `RST_CYC` parameter is ignored.

## Test plan
All scenarios use defaults G=2, S=4, R=8 unless stated.
- Reset release: all outputs = 0, `req_ready` = 1, `busy` = 0 after the first edge with `rst_n` = 1.
- Select with `req_addr` = 10'h2A5, `req_ena` = 1, accepted at edge k:
  - `spine_ena` = 0 from k.
  - `spine_sel` = 2A5 at k+2.
  - `spine_ena` = 1 at k+6.
  - `um_rst_n` = 1 and `done` pulse at k+14 (macro defined).
  - Macro undefined: `done` and `um_rst_n` = 1 at k+6.
- Switch while ACTIVE on 2A5, new request 10'h013: `spine_ena` drops at k, `spine_sel` changes at k+2. `spine_ena` and `spine_sel` change are never high on the same cycle (break-before-make).
- Disable-only request, `req_ena` = 0, address 10'h100: `spine_sel` = 100 at k+2, `done` at k+6, state IDLE, `spine_ena` = 0, `um_rst_n` = 0.
- Backpressure: `req_valid` held high with a second address during a sequence. It is accepted exactly on the `done` edge, and exactly two `done` pulses are seen.
- `rst_n` asserted at k+3 mid-sequence: next edge shows `spine_sel` = 0, `spine_ena` = 0, `um_rst_n` = 0, state IDLE.
